// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network tile blocks.
//   state_t     : decoder FSM state encoding (S_IDLE, S_COUNT)
//   CNT_W_DEF   : default width of rate / ISI / window counters
//   ISI_INVALID : ISI value reported until two spikes have been seen
package snn_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int ISI_INVALID = 0;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky overflow flag.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear of value and sat (wins over inc)
//   inc      : increment request
//   value    : current count, holds at all-ones
//   sat      : set when an increment is requested while value is all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         sat
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            if (value == '1) begin
                sat <= 1'b1;
            end else begin
                value <= value + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder. Counts spikes over a programmable window of
// N cycles, tracks the most recent inter-spike interval, and hands each
// window result to a one-deep output buffer.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   spike       : spike line, sampled every cycle while counting
//   enable      : high = decode back-to-back windows, low = abort and idle
//   window_len  : window length in cycles, sampled at each window start
//                 (0 selects 2^CNT_W)
//   rate        : spike count of the last buffered window (saturating)
//   isi         : last inter-spike interval captured with rate
//   rate_sat    : window count was clamped at 2^CNT_W-1
//   out_valid   : buffer holds an unread result
//   out_ready   : consumer accepts the buffered result
//   dropped     : sticky, a result was lost because the buffer was full
//
// Handshake: a transfer happens on any rising edge where out_valid and
// out_ready are both high. out_ready while out_valid is low does nothing.
// A window closing on a transfer edge refills the buffer, so out_valid
// stays high; closing while the buffer is full and not being read discards
// the new result and sets dropped.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             enable,
    input  logic [CNT_W-1:0] window_len,
    output logic [CNT_W-1:0] rate,
    output logic [CNT_W-1:0] isi,
    output logic             rate_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             dropped
);

    state_t state_q, state_d;

    logic             sampling;
    logic             entering;
    logic             close;
    logic             transfer;

    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] win_q;

    logic [CNT_W-1:0] spk_cnt;
    logic             spk_sat;
    logic [CNT_W-1:0] gap_cnt;
    logic             gap_sat;

    logic             has_prev_q;
    logic [CNT_W-1:0] last_isi_q;

    logic [CNT_W-1:0] isi_cand;
    logic [CNT_W-1:0] isi_now;
    logic [CNT_W-1:0] rate_now;
    logic             sat_now;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sampling = 1'b0;
        entering = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_COUNT;
                    entering = 1'b1;
                end
            end
            S_COUNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    sampling = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // win_q == 0 gives win_q-1 == all ones, i.e. a 2^CNT_W-cycle window,
    // so the cycle counter never needs to wrap.
    assign close    = sampling && (cyc_q == (win_q - 1'b1));
    assign transfer = out_valid && out_ready;

    // ---------------- cycle counter / window register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            win_q <= '0;
        end else if (entering) begin
            cyc_q <= '0;
            win_q <= window_len;
        end else if (sampling) begin
            if (close) begin
                cyc_q <= '0;
                win_q <= window_len;
            end else begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    // ---------------- spike and gap counters ----------------
    // Spike counter restarts at every window close; its final value is
    // captured combinationally (rate_now) so the closing edge's spike counts.
    sat_counter #(.W(CNT_W)) u_spike_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!sampling || close),
        .inc   (sampling && spike),
        .value (spk_cnt),
        .sat   (spk_sat)
    );

    // Gap counter runs across window boundaries and restarts on each spike.
    sat_counter #(.W(CNT_W)) u_gap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!sampling || spike),
        .inc   (sampling),
        .value (gap_cnt),
        .sat   (gap_sat)
    );

    assign isi_cand = (gap_sat || (gap_cnt == '1)) ? '1 : gap_cnt + 1'b1;
    assign isi_now  = (spike && has_prev_q) ? isi_cand : last_isi_q;
    assign rate_now = spike ? ((spk_cnt == '1) ? '1 : spk_cnt + 1'b1) : spk_cnt;
    assign sat_now  = spk_sat || (spike && (spk_cnt == '1));

    // ---------------- ISI tracker ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_prev_q <= 1'b0;
            last_isi_q <= CNT_W'(ISI_INVALID);
        end else if (!sampling) begin
            has_prev_q <= 1'b0;
            last_isi_q <= CNT_W'(ISI_INVALID);
        end else if (spike) begin
            if (has_prev_q) begin
                last_isi_q <= isi_cand;
            end
            has_prev_q <= 1'b1;
        end
    end

    // ---------------- output buffer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate      <= '0;
            isi       <= '0;
            rate_sat  <= 1'b0;
            out_valid <= 1'b0;
            dropped   <= 1'b0;
        end else if (close) begin
            if (!out_valid || transfer) begin
                rate      <= rate_now;
                isi       <= isi_now;
                rate_sat  <= sat_now;
                out_valid <= 1'b1;
            end else begin
                dropped <= 1'b1;
            end
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
